// File: rtl/key_irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_irq_ctrl_pkg
//  Description : Shared bus encodings and memory map for the key interrupt
//                controller and its neighbours on the CPU memory bus.
//  Revision    : 1.0  initial release
// ============================================================================
package key_irq_ctrl_pkg;

    // CPU bus command encodings; any other value is idle
    localparam logic [1:0] MREAD  = 2'b10;
    localparam logic [1:0] MWRITE = 2'b01;

    // Device base addresses on the 9-bit CPU address bus
    localparam logic [8:0] LED_BASE = 9'h100;
    localparam logic [8:0] SW_BASE  = 9'h140;
    localparam logic [8:0] IRQ_BASE = 9'h180;

    localparam int REG_W = 16;

    typedef enum logic [1:0] {
        BUS_IDLE  = 2'd0,
        BUS_READ  = 2'd1,
        BUS_WRITE = 2'd2
    } bus_op_e;

    // Collapses the raw command into one of three bus operations
    function automatic bus_op_e decode_cmd(input logic [1:0] cmd);
        bus_op_e op;
        op = BUS_IDLE;
        if (cmd == MREAD) begin
            op = BUS_READ;
        end else if (cmd == MWRITE) begin
            op = BUS_WRITE;
        end
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_irq_ctrl_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_irq_ctrl_debounce
//  Description : One pushbutton: 2-flop synchroniser, stable-level debounce
//                counter and a one-cycle pulse on each accepted press.
//  Revision    : 1.0  initial release
// ============================================================================
module key_irq_ctrl_debounce
    import key_irq_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 500000,
    parameter int CNT_W      = 19
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_pressed,
    output logic o_press
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_q,   sync_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             press_q,  press_d;

    // Next state: count while the synchronised level differs from the accepted one
    always_comb begin
        sync_d   = {sync_q[0], i_key_n};
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == C_CNT_MAX) begin
                stable_d = sync_q[1];
                // Only the released-to-held transition is an event
                press_d  = ~sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; keys idle released (high) out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign o_pressed = ~stable_q;
    assign o_press   = press_q;

endmodule
`default_nettype wire

// File: rtl/key_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : key_irq_ctrl
//  Description : Debounced pushbutton interrupt controller with PEND (W1C)
//                and EN registers on the CPU memory bus and a registered,
//                level-sensitive irq output.
//  Revision    : 1.0  initial release
// ============================================================================
module key_irq_ctrl
    import key_irq_ctrl_pkg::*;
#(
    parameter int         NKEYS      = 2,
    parameter int         DEB_CYCLES = 500000,
    parameter int         CNT_W      = 19,
    parameter logic [8:0] BASE_ADDR  = IRQ_BASE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NKEYS-1:0] key_n,
    input  logic [8:0]       mem_addr,
    input  logic [1:0]       mem_cmd,
    input  logic [15:0]      write_data,
    output logic [15:0]      read_data,
    output logic [NKEYS-1:0] pressed,
    output logic             irq
);

    localparam logic [8:0] C_PEND_ADDR = BASE_ADDR;
    localparam logic [8:0] C_EN_ADDR   = BASE_ADDR + 9'd1;

    logic [NKEYS-1:0] w_press;
    logic [NKEYS-1:0] pending_q, pending_d;
    logic [NKEYS-1:0] enable_q,  enable_d;
    logic             irq_q,     irq_d;
    bus_op_e          w_op;
    logic             w_hit_pend, w_hit_en;
    logic [REG_W-1:0] w_rdata;
    logic             w_unused;

    generate
        for (genvar gi = 0; gi < NKEYS; gi++) begin : g_key
            key_irq_ctrl_debounce #(
                .DEB_CYCLES (DEB_CYCLES),
                .CNT_W      (CNT_W)
            ) u_debounce (
                .clk       (clk),
                .rst       (reset),
                .i_key_n   (key_n[gi]),
                .o_pressed (pressed[gi]),
                .o_press   (w_press[gi])
            );
        end
    endgenerate

    // Bus decode, register next-state and read mux
    always_comb begin
        w_op       = decode_cmd(mem_cmd);
        w_hit_pend = (mem_addr == C_PEND_ADDR);
        w_hit_en   = (mem_addr == C_EN_ADDR);

        // W1C is applied first so a press in the same cycle re-sets the bit
        pending_d = pending_q;
        if (w_op == BUS_WRITE && w_hit_pend) begin
            pending_d = pending_q & ~write_data[NKEYS-1:0];
        end
        pending_d = pending_d | w_press;

        enable_d = enable_q;
        if (w_op == BUS_WRITE && w_hit_en) begin
            enable_d = write_data[NKEYS-1:0];
        end

        irq_d = |(pending_q & enable_q);

        w_rdata = '0;
        if (w_hit_pend) begin
            w_rdata[NKEYS-1:0] = pending_q;
        end else if (w_hit_en) begin
            w_rdata[NKEYS-1:0] = enable_q;
        end
    end

    // Pending, enable and irq registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            enable_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            enable_q  <= enable_d;
            irq_q     <= irq_d;
        end
    end

    // Release the shared bus unless this device is the read target
    assign read_data = (w_op == BUS_READ && (w_hit_pend || w_hit_en)) ? w_rdata : 16'bz;
    assign irq       = irq_q;

    // Upper store-data bits have no register behind them
    assign w_unused = &{1'b0, write_data[REG_W-1:NKEYS]};

endmodule
`default_nettype wire

// File: tb/tb_key_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_irq_ctrl
//  Description : Scoreboard bench for key_irq_ctrl (DEB_CYCLES=4, NKEYS=2).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_key_irq_ctrl;

    localparam logic [1:0] C_MREAD  = 2'b10;
    localparam logic [1:0] C_MWRITE = 2'b01;
    localparam logic [1:0] C_IDLE   = 2'b00;
    localparam logic [8:0] C_PEND   = 9'h180;
    localparam logic [8:0] C_EN     = 9'h181;
    localparam logic [8:0] C_LED    = 9'h100;
    localparam logic [15:0] C_OTHER = 16'hA5A0;

    typedef struct {
        bit          is_probe;
        logic [15:0] exp;
        string       name;
    } sb_item_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  key_n;
    logic [8:0]  mem_addr;
    logic [1:0]  mem_cmd;
    logic [15:0] write_data;
    wire  [15:0] read_data;
    logic [1:0]  pressed;
    logic        irq;

    logic        probe = 1'b0;
    logic        done = 1'b0;
    logic        final_checked = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    sb_item_t    sb_q[$];

    always #5 clk = ~clk;

    // Another bus device (LED) answering at 0x100; must never contend with the DUT
    assign read_data = (mem_cmd == C_MREAD && mem_addr == C_LED) ? C_OTHER : 16'bz;

    key_irq_ctrl #(
        .NKEYS      (2),
        .DEB_CYCLES (4),
        .CNT_W      (3),
        .BASE_ADDR  (9'h180)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_n      (key_n),
        .mem_addr   (mem_addr),
        .mem_cmd    (mem_cmd),
        .write_data (write_data),
        .read_data  (read_data),
        .pressed    (pressed),
        .irq        (irq)
    );

    // Monitor: pops one expectation per read or status probe
    always @(negedge clk) begin
        sb_item_t    item;
        logic [15:0] actual;
        if (probe || mem_cmd == C_MREAD) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_underflow: output seen with no expectation queued");
            end else begin
                item   = sb_q.pop_front();
                actual = item.is_probe ? {13'b0, irq, pressed} : read_data;
                if (actual !== item.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h", item.name, actual, item.exp);
                end
            end
        end
        if (done && !final_checked) begin
            n_cmp++;
            if (sb_q.size() != 0) begin
                n_bad++;
                $display("FAIL sb_leftover: got %0d unchecked expected 0", sb_q.size());
            end
            final_checked <= 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [8:0] addr, input logic [15:0] data);
        mem_addr   = addr;
        write_data = data;
        mem_cmd    = C_MWRITE;
        tick(1);
        mem_cmd    = C_IDLE;
        write_data = 16'h0000;
    endtask

    task automatic bus_read(input logic [8:0] addr, input logic [15:0] exp, input string name);
        sb_q.push_back('{1'b0, exp, name});
        mem_addr = addr;
        mem_cmd  = C_MREAD;
        tick(1);
        mem_cmd  = C_IDLE;
    endtask

    // Expects {irq, pressed} as seen after the most recent clock edge
    task automatic check_status(input logic exp_irq, input logic [1:0] exp_pressed, input string name);
        sb_q.push_back('{1'b1, {13'b0, exp_irq, exp_pressed}, name});
        probe = 1'b1;
        tick(1);
        probe = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        key_n      = 2'b11;
        mem_addr   = 9'h000;
        mem_cmd    = C_IDLE;
        write_data = 16'h0000;
        tick(3);
        reset = 1'b0;

        // 1: reset state
        check_status(1'b0, 2'b00, "reset_status");
        bus_read(C_PEND, 16'h0000, "reset_pend");
        bus_read(C_EN,   16'h0000, "reset_en");
        bus_read(C_LED,  C_OTHER,  "reset_led_no_contention");

        // 2: single press latency with EN[0] set
        bus_write(C_EN, 16'h0001);
        key_n = 2'b10;
        tick(5);
        check_status(1'b0, 2'b00, "press_5cyc");
        check_status(1'b0, 2'b01, "press_6cyc_pressed");
        check_status(1'b0, 2'b01, "press_7cyc_no_irq");
        check_status(1'b1, 2'b01, "press_8cyc_irq");
        bus_read(C_PEND, 16'h0001, "press_pend");
        key_n = 2'b11;
        tick(8);
        check_status(1'b1, 2'b00, "release_irq_held");
        bus_write(C_PEND, 16'h0001);
        tick(1);
        check_status(1'b0, 2'b00, "w1c_irq_drop");

        // 3: bouncing key never accepted
        for (int i = 0; i < 5; i++) begin
            key_n = 2'b10;
            tick(2);
            key_n = 2'b11;
            tick(2);
        end
        tick(6);
        check_status(1'b0, 2'b00, "bounce_status");
        bus_read(C_PEND, 16'h0000, "bounce_pend");

        // 4: partial W1C and re-enable
        key_n = 2'b00;
        tick(8);
        key_n = 2'b11;
        tick(8);
        check_status(1'b1, 2'b00, "both_irq");
        bus_read(C_PEND, 16'h0003, "both_pend");
        bus_read(C_LED,  C_OTHER,  "pend_led_no_contention");
        bus_write(C_PEND, 16'hFFF1);
        tick(1);
        check_status(1'b0, 2'b00, "w1c_bit0_irq_low");
        bus_read(C_PEND, 16'h0002, "w1c_bit0_pend");
        bus_write(C_EN, 16'h0003);
        check_status(1'b0, 2'b00, "en3_same_cycle");
        check_status(1'b1, 2'b00, "en3_next_cycle");
        bus_read(C_EN, 16'h0003, "en3_readback");

        // 5: press edge coincident with W1C of the same bit
        bus_write(C_PEND, 16'h0003);
        bus_write(C_EN,   16'h0000);
        key_n = 2'b10;
        tick(6);
        bus_write(C_PEND, 16'h0001);
        bus_read(C_PEND, 16'h0001, "set_wins");
        key_n = 2'b11;
        tick(8);

        // 6: reset with key held and pending set, then re-arm
        bus_write(C_PEND, 16'h0003);
        key_n = 2'b01;
        tick(8);
        bus_write(C_EN, 16'h0003);
        tick(1);
        check_status(1'b1, 2'b10, "pre_reset_status");
        reset = 1'b1;
        tick(1);
        check_status(1'b0, 2'b00, "in_reset_status");
        bus_read(C_PEND, 16'h0000, "in_reset_pend");
        reset = 1'b0;
        tick(5);
        check_status(1'b0, 2'b00, "rearm_5cyc");
        bus_read(C_PEND, 16'h0000, "rearm_6cyc_pend");
        check_status(1'b0, 2'b10, "rearm_7cyc_pressed");
        bus_read(C_PEND, 16'h0002, "rearm_8cyc_pend");
        bus_read(C_EN,   16'h0000, "rearm_en_cleared");
        check_status(1'b0, 2'b10, "rearm_no_irq");
        key_n = 2'b11;
        tick(2);

        done = 1'b1;
        for (int i = 0; i < 10 && !final_checked; i++) begin
            tick(1);
        end
        if (!final_checked) begin
            $display("FAIL monitor_timeout: got no final check expected one");
            $fatal(1, "monitor did not respond");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
